sram_mem_controller: RTL and testbench

Memory-stage controller between the EX-stage pipeline register and the MEM-stage pipeline register. It turns one 32-bit load/store request into two 16-bit accesses on an external single-port SRAM. While a request is in progress it drives `ready` low, which the datapath uses as the pipeline `Freeze`. Load data is returned on `read_data` for capture into the MEM-stage register.

---
 rtl/sram_mem_controller.sv | 180 ++++++++++++++++++
 tb/tb_sram_mem_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_mem_controller.sv
// ---------------------------------------------------------------------------
// sram_mem_controller
//
// Purpose:
//   MEM-stage bridge between the 32-bit pipeline and a 16-bit single-port
//   SRAM. A load or store is split into a low-halfword access followed by a
//   high-halfword access. Each access is held for ACCESS_CYCLES cycles. While
//   a request is outstanding, `ready` is low and the datapath uses it as the
//   pipeline freeze.
//
// Parameters:
//   ACCESS_CYCLES  cycles each 16-bit access is held (>= 1)
//   BASE_ADDR      byte address that maps to SRAM word 0
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   rd_en          load request, held until ready = 1
//   wr_en          store request, held until ready = 1 (wins over rd_en)
//   address        byte address of the request
//   write_data     store data
//   read_data      data of the last completed load
//   ready          0 = freeze the pipeline
//   sram_addr      SRAM halfword address
//   sram_we_n      SRAM write enable, active-low
//   sram_dq_out    data driven towards the SRAM
//   sram_dq_oe     drive enable for sram_dq_out
//   sram_dq_in     data returned by the SRAM
// ---------------------------------------------------------------------------
module sram_mem_controller #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic [15:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [15:0] sram_dq_in
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_DONE
    } state_t;

    // The counter only has to reach ACCESS_CYCLES-1 before the phase ends.
    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic            r_is_wr;
    logic [31:0]     r_hold;
    logic [31:0]     r_read_data;

    logic [31:0]     w_off;
    logic [16:0]     w_word;
    logic            w_req;
    logic            w_phase_last;
    logic            w_unused_off_bits;

    // Address translation. The offset wraps silently. The two byte-lane bits
    // are dropped, which forces every access onto a word boundary. Offset
    // bits above the SRAM's range are also dropped.
    assign w_off             = address - BASE_ADDR;
    assign w_word            = w_off[18:2];
    assign w_unused_off_bits = ^{w_off[31:19], w_off[1:0]};

    assign w_req        = rd_en | wr_en;
    assign w_phase_last = (r_cnt == CNT_LAST);

    // A request is frozen from the idle cycle where it first appears through
    // the last high-half cycle. The pipeline is released only in DONE.
    assign ready     = ~w_req | (r_state == S_DONE);
    assign read_data = r_read_data;

    // ---------------------------------------------------------------------
    // Next-state and SRAM pin decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        sram_addr    = '0;
        sram_we_n    = 1'b1;
        sram_dq_out  = '0;
        sram_dq_oe   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_next = S_LOW;
                end
            end

            S_LOW: begin
                sram_addr = {w_word, 1'b0};
                if (r_is_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[15:0];
                end
                if (w_phase_last) begin
                    w_state_next = S_HIGH;
                end
            end

            S_HIGH: begin
                sram_addr = {w_word, 1'b1};
                if (r_is_wr) begin
                    sram_we_n   = 1'b0;
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = write_data[31:16];
                end
                if (w_phase_last) begin
                    w_state_next = S_DONE;
                end
            end

            S_DONE: begin
                w_state_next = S_IDLE;
            end

            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State, phase counter, request type and load data
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_is_wr     <= 1'b0;
            r_hold      <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_state_next;

            // The counter restarts on every state change, so each phase
            // starts counting from zero.
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (r_state == S_LOW || r_state == S_HIGH) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            // Capture the request type once. Later changes on the enables
            // are ignored until the request returns to IDLE.
            if (r_state == S_IDLE && w_req) begin
                r_is_wr <= wr_en;
            end

            // For reads, the SRAM data is sampled on the last cycle of each
            // phase. The high half arrives on the same edge that enters DONE,
            // so read_data uses the incoming half directly.
            if (!r_is_wr && w_phase_last) begin
                if (r_state == S_LOW) begin
                    r_hold[15:0] <= sram_dq_in;
                end else if (r_state == S_HIGH) begin
                    r_hold[31:16] <= sram_dq_in;
                    r_read_data   <= {sram_dq_in, r_hold[15:0]};
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_mem_controller.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_controller
//
// Directed testbench for sram_mem_controller. A small SRAM array answers the
// DUT's pin activity.
//
// A transaction-level model tracks each request as a cycle index c:
//   c = 0        idle or first cycle
//   c = 1..A     low phase
//   c = A+1..2A  high phase
//   c = 2A+1     done
// From c and the request inputs, a compare process predicts every output on
// every cycle. Hand-computed literal checks pin the model to known values.
// ---------------------------------------------------------------------------
module tb_sram_mem_controller;

    localparam int          A    = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;

    logic [15:0] mem [0:63];

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // model state
    int          m_c  = 0;
    bit          m_wr = 1'b0;
    logic [31:0] m_rd = '0;

    // per-cycle observations of the most recent request (index = frozen cycle)
    logic [17:0] obs_addr [0:63];
    logic [15:0] obs_dq   [0:63];
    logic        obs_we_n [0:63];
    logic        obs_oe   [0:63];

    sram_mem_controller #(
        .ACCESS_CYCLES (A),
        .BASE_ADDR     (BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_en       (rd_en),
        .wr_en       (wr_en),
        .address     (address),
        .write_data  (write_data),
        .read_data   (read_data),
        .ready       (ready),
        .sram_addr   (sram_addr),
        .sram_we_n   (sram_we_n),
        .sram_dq_out (sram_dq_out),
        .sram_dq_oe  (sram_dq_oe),
        .sram_dq_in  (sram_dq_in)
    );

    always #5 clk = ~clk;

    // SRAM: asynchronous read, write during the low part of the cycle
    assign sram_dq_in = mem[sram_addr[5:0]];

    always @(negedge clk) begin
        if (!sram_we_n && sram_dq_oe) begin
            mem[sram_addr[5:0]] = sram_dq_out;
        end
    end

    function automatic int hw_base(input logic [31:0] a);
        logic [31:0] off;
        off = a - BASE;
        return int'((off >> 2) & 32'h1FFFF) * 2;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of request progress and load data
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_c  = 0;
            m_rd = '0;
        end else if (m_c == 0) begin
            if (rd_en || wr_en) begin
                m_c  = 1;
                m_wr = wr_en;
            end
        end else begin
            if (m_c == 2 * A && !m_wr) begin
                m_rd = {mem[(hw_base(address) + 1) % 64], mem[hw_base(address) % 64]};
            end
            m_c = (m_c == 2 * A + 1) ? 0 : m_c + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            bit          in_low;
            bit          in_high;
            bit          wr_act;
            logic [17:0] e_addr;
            logic [15:0] e_dq;
            in_low  = (m_c >= 1) && (m_c <= A);
            in_high = (m_c > A) && (m_c <= 2 * A);
            wr_act  = (in_low || in_high) && m_wr;
            e_addr  = (in_low || in_high) ? 18'(hw_base(address) + (in_high ? 1 : 0)) : 18'd0;
            e_dq    = wr_act ? (in_low ? write_data[15:0] : write_data[31:16]) : 16'h0;
            chk("cyc_sram_addr", 32'(sram_addr), 32'(e_addr));
            chk("cyc_we_n", 32'(sram_we_n), 32'(!wr_act));
            chk("cyc_dq_oe", 32'(sram_dq_oe), 32'(wr_act));
            chk("cyc_dq_out", 32'(sram_dq_out), 32'(e_dq));
            chk("cyc_ready", 32'(ready), 32'(!(rd_en || wr_en) || (m_c == 2 * A + 1)));
            chk("cyc_read_data", read_data, m_rd);
        end
    end

    // Issue one request starting at posedge+1 and return at posedge+1 after DONE
    task automatic run_req(input string nm, input logic rd, input logic wr,
                           input logic [31:0] a, input logic [31:0] d,
                           input bit keep, output int frozen);
        int n;
        n = 0;
        frozen = 0;
        rd_en = rd;
        wr_en = wr;
        address = a;
        write_data = d;
        @(negedge clk);
        while (!ready && n < 50) begin
            obs_addr[frozen] = sram_addr;
            obs_dq[frozen]   = sram_dq_out;
            obs_we_n[frozen] = sram_we_n;
            obs_oe[frozen]   = sram_dq_oe;
            frozen++;
            n++;
            @(negedge clk);
        end
        chk({nm, "_completes"}, 32'(ready), 32'd1);
        $display("[TB] %s addr=0x%08h wdata=0x%08h frozen=%0d read_data=0x%08h",
                 nm, a, d, frozen, read_data);
        @(posedge clk);
        #1;
        if (!keep) begin
            rd_en = 1'b0;
            wr_en = 1'b0;
        end
    endtask

    initial begin
        int fz;
        int fz2;
        for (int i = 0; i < 64; i++) mem[i] = 16'h0;

        // reset
        #1 reset = 1'b1;
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_read_data", read_data, 32'h0);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        reset = 1'b0;

        // store 0xDEADBEEF to 1032 -> halfwords 4/5
        run_req("store", 1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, fz);
        chk("store_frozen", 32'(fz), 32'd5);
        for (int k = 1; k <= 2; k++) begin
            chk("store_low_addr", 32'(obs_addr[k]), 32'd4);
            chk("store_low_dq", 32'(obs_dq[k]), 32'h0000BEEF);
            chk("store_low_we_n", 32'(obs_we_n[k]), 32'd0);
            chk("store_high_addr", 32'(obs_addr[k + 2]), 32'd5);
            chk("store_high_dq", 32'(obs_dq[k + 2]), 32'h0000DEAD);
            chk("store_high_we_n", 32'(obs_we_n[k + 2]), 32'd0);
        end
        chk("store_mem4", 32'(mem[4]), 32'h0000BEEF);
        chk("store_mem5", 32'(mem[5]), 32'h0000DEAD);

        // load from 1032
        run_req("load", 1'b1, 1'b0, 32'd1032, 32'h0, 1'b0, fz);
        chk("load_frozen", 32'(fz), 32'd5);
        chk("load_read_data", read_data, 32'hDEADBEEF);
        for (int k = 0; k < 5; k++) begin
            chk("load_we_n", 32'(obs_we_n[k]), 32'd1);
            chk("load_dq_oe", 32'(obs_oe[k]), 32'd0);
        end

        // idle for 10 cycles (the per-cycle checker covers each cycle)
        repeat (10) begin @(posedge clk); #1; end
        chk("idle_ready", 32'(ready), 32'd1);
        chk("idle_read_data_held", read_data, 32'hDEADBEEF);

        // reset during the high phase of a write to 1040
        rd_en = 1'b0; wr_en = 1'b1; address = 32'd1040; write_data = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        wr_en = 1'b0;
        #1;
        chk("midrst_sram_addr", 32'(sram_addr), 32'd0);
        chk("midrst_we_n", 32'(sram_we_n), 32'd1);
        chk("midrst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("midrst_dq_out", 32'(sram_dq_out), 32'd0);
        chk("midrst_read_data", read_data, 32'h0);
        chk("midrst_ready", 32'(ready), 32'd1);
        $display("[TB] reset pulsed during high phase of write to 0x%08h", 32'd1040);
        @(posedge clk); #1;
        reset = 1'b0;

        run_req("store_after_reset", 1'b0, 1'b1, 32'd1024, 32'h12345678, 1'b0, fz);
        chk("sar_frozen", 32'(fz), 32'd5);
        chk("sar_mem0", 32'(mem[0]), 32'h00005678);
        chk("sar_mem1", 32'(mem[1]), 32'h00001234);

        run_req("load_1024", 1'b1, 1'b0, 32'd1024, 32'h0, 1'b0, fz);
        chk("load1024_read_data", read_data, 32'h12345678);

        // both enables -> write, read_data untouched
        run_req("both_enables", 1'b1, 1'b1, 32'd1036, 32'h0BADCAFE, 1'b0, fz);
        chk("both_read_data", read_data, 32'h12345678);
        chk("both_mem6", 32'(mem[6]), 32'h0000CAFE);
        chk("both_mem7", 32'(mem[7]), 32'h00000BAD);
        chk("both_we_n_low", 32'(obs_we_n[1]), 32'd0);

        // back-to-back store then load at 1028
        run_req("b2b_store", 1'b0, 1'b1, 32'd1028, 32'h0000AAAA, 1'b1, fz);
        run_req("b2b_load", 1'b1, 1'b0, 32'd1028, 32'h0, 1'b0, fz2);
        chk("b2b_frozen_total", 32'(fz + fz2), 32'd10);
        chk("b2b_read_data", read_data, 32'h0000AAAA);

        repeat (3) begin @(posedge clk); #1; end
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
